// File: rtl/edl_peak_pkg.sv
// Shared constants and types for the peak detector: register map, tracker
// state encoding and the signed limit values used as "nothing seen yet" markers.
package edl_peak_pkg;

    localparam logic [1:0] ADDR_MAX    = 2'd0;
    localparam logic [1:0] ADDR_MIN    = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic {
        EMPTY,
        TRACKING
    } trk_state_t;

    // Most-negative w-bit value, sign-extended to 32 bits (MAX idle value).
    function automatic logic [31:0] neg_limit(input int w);
        return 32'hFFFF_FFFF << (w - 1);
    endfunction

    // Most-positive w-bit value, zero-extended to 32 bits (MIN idle value).
    function automatic logic [31:0] pos_limit(input int w);
        return ~(32'hFFFF_FFFF << (w - 1));
    endfunction

endpackage

// File: rtl/edl_peak_detector_if.sv
// Avalon-MM slave bus of the peak detector, zero-wait-state reads.
interface edl_peak_detector_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, read_n, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/edl_peak_tracker.sv
// Two-stage max/min/count tracker: S1 registers the sample, S2 compares and updates.
//   state    | meaning
//   EMPTY    | no sample accepted since the last clear; MAX/MIN hold limit values
//   TRACKING | at least one sample accepted; MAX/MIN/COUNT are live
module edl_peak_tracker
    import edl_peak_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_data,
    output logic signed [DATA_W-1:0] max_val,
    output logic signed [DATA_W-1:0] min_val,
    output logic [31:0]              count,
    output logic                     sat,
    output logic                     empty
);
    localparam logic signed [DATA_W-1:0] MAX_RST = DATA_W'(neg_limit(DATA_W));
    localparam logic signed [DATA_W-1:0] MIN_RST = DATA_W'(pos_limit(DATA_W));

    trk_state_t                trk_state, trk_state_next;
    logic                      s1_valid;
    logic signed [DATA_W-1:0]  s1_data;
    logic signed [DATA_W-1:0]  max_next, min_next;
    logic [31:0]               count_next;
    logic                      sat_next;

    // A clear drops whatever is being captured, so nothing leaks past it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= sample_valid && !clear;
            s1_data  <= sample_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trk_state <= EMPTY;
            max_val   <= MAX_RST;
            min_val   <= MIN_RST;
            count     <= '0;
            sat       <= 1'b0;
        end else begin
            trk_state <= trk_state_next;
            max_val   <= max_next;
            min_val   <= min_next;
            count     <= count_next;
            sat       <= sat_next;
        end
    end

    always_comb begin
        trk_state_next = trk_state;
        max_next       = max_val;
        min_next       = min_val;
        count_next     = count;
        sat_next       = sat;
        if (clear) begin
            trk_state_next = EMPTY;
            max_next       = MAX_RST;
            min_next       = MIN_RST;
            count_next     = '0;
            sat_next       = 1'b0;
        end else if (s1_valid) begin
            case (trk_state)
                EMPTY: begin
                    trk_state_next = TRACKING;
                    max_next       = s1_data;
                    min_next       = s1_data;
                    count_next     = 32'd1;
                end
                TRACKING: begin
                    if (s1_data > max_val) max_next = s1_data;
                    if (s1_data < min_val) min_next = s1_data;
                    if (count != 32'hFFFF_FFFF) count_next = count + 32'd1;
                    sat_next = sat || (count >= 32'hFFFF_FFFE);
                end
                default: trk_state_next = EMPTY;
            endcase
        end
    end

    assign empty = (trk_state == EMPTY);

endmodule

// File: rtl/edl_peak_detector.sv
// Peak detector top: Avalon decode, clear merge, MIN/COUNT snapshot shadows
// and the combinational read mux around the tracker.
module edl_peak_detector
    import edl_peak_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_data,
    input  logic                     peak_reset,
    edl_peak_detector_if.slave       avs,
    output logic                     empty
);
    localparam logic signed [DATA_W-1:0] MIN_RST = DATA_W'(pos_limit(DATA_W));

    logic                     rd_max, wr_clear, clear;
    logic signed [DATA_W-1:0] max_val, min_val, shadow_min;
    logic [31:0]              count, shadow_count;
    logic                     sat;
    logic                     unused_wdata;

    assign rd_max   = avs.chipselect && !avs.read_n && (avs.address == ADDR_MAX);
    assign wr_clear = avs.chipselect && !avs.write_n && (avs.address == ADDR_STATUS)
                      && avs.writedata[0];
    assign clear    = peak_reset || wr_clear;
    assign unused_wdata = ^avs.writedata[31:1];

    edl_peak_tracker #(.DATA_W(DATA_W)) u_trk (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .max_val      (max_val),
        .min_val      (min_val),
        .count        (count),
        .sat          (sat),
        .empty        (empty)
    );

    // Reading MAX freezes MIN/COUNT so a following MIN, COUNT read is coherent.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shadow_min   <= MIN_RST;
            shadow_count <= '0;
        end else if (rd_max) begin
            shadow_min   <= min_val;
            shadow_count <= count;
        end
    end

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_MAX:    avs.readdata = 32'(max_val);
            ADDR_MIN:    avs.readdata = 32'(shadow_min);
            ADDR_COUNT:  avs.readdata = shadow_count;
            ADDR_STATUS: avs.readdata = {30'd0, sat, empty};
            default:     avs.readdata = '0;
        endcase
    end

endmodule
